ultrasonic_echo_responder: RTL and testbench

//  Ultrasonic range-sensor emulator (HC-SR04 style): the responder side of the proximity

---
 rtl/ultrasonic_echo_responder.sv | 214 +++++++++++++++++++++
 tb/tb_ultrasonic_echo_responder.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_echo_responder.sv
// ---------------------------------------------------------------------------
// ultrasonic_echo_responder
//
// Purpose:
//   Emulates the responder side of an HC-SR04 style ultrasonic range sensor.
//   A trigger pulse of sufficient width on trig starts a fixed acoustic-burst
//   delay, after which echo is driven high for a time proportional to the
//   programmed distance.  A dead time (holdoff) follows every echo during
//   which trigger activity is ignored.
//
// Ports:
//   clk        in   1  system clock
//   rst        in   1  synchronous active-high reset
//   trig       in   1  trigger from initiator (asynchronous, synchronised here)
//   dist_cm    in   9  emulated distance in cm, sampled on accepted trigger fall
//   no_object  in   1  1 = no echo target, sampled together with dist_cm
//   echo       out  1  echo pulse back to the initiator
//   busy       out  1  high from accepted trigger fall through end of holdoff
//   short_trig out  1  one-cycle pulse when a trigger was too short
// ---------------------------------------------------------------------------
module ultrasonic_echo_responder #(
  parameter int unsigned CYCLES_PER_CM   = 5800,
  parameter int unsigned MIN_TRIG_CYCLES = 1000,
  parameter int unsigned BURST_CYCLES    = 20000,
  parameter int unsigned MAX_ECHO_CYCLES = 3800000,
  parameter int unsigned HOLDOFF_CYCLES  = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [8:0] dist_cm,
  input  logic       no_object,
  output logic       echo,
  output logic       busy,
  output logic       short_trig
);

  // Echo-width counter size; widened if another phase needs a larger count.
  localparam int unsigned CW_ECHO = $clog2(MAX_ECHO_CYCLES + 1);
  localparam int unsigned CW_BRST = $clog2(BURST_CYCLES + 1);
  localparam int unsigned CW_HOLD = $clog2(HOLDOFF_CYCLES + 1);
  localparam int unsigned CW_TRIG = $clog2(MIN_TRIG_CYCLES + 1);
  localparam int unsigned CW_A    = (CW_ECHO > CW_BRST) ? CW_ECHO : CW_BRST;
  localparam int unsigned CW_B    = (CW_HOLD > CW_TRIG) ? CW_HOLD : CW_TRIG;
  localparam int unsigned CW      = (CW_A > CW_B) ? CW_A : CW_B;

  // Product width holds 511 * CYCLES_PER_CM exactly; compare width also
  // covers the clamp limit so nothing is truncated before the compare.
  localparam int unsigned PW = 9 + $clog2(CYCLES_PER_CM + 1);
  localparam int unsigned XW = (PW > CW_ECHO) ? PW : CW_ECHO;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_SAT  = {CW{1'b1}};
  localparam logic [CW-1:0] MIN_C    = CW'(MIN_TRIG_CYCLES);
  localparam logic [CW-1:0] BURST_C  = CW'(BURST_CYCLES);
  localparam logic [CW-1:0] HOLD_C   = CW'(HOLDOFF_CYCLES);
  localparam logic [CW-1:0] MAX_C    = CW'(MAX_ECHO_CYCLES);
  localparam logic [XW-1:0] CPC_X    = XW'(CYCLES_PER_CM);
  localparam logic [XW-1:0] MAX_X    = XW'(MAX_ECHO_CYCLES);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_TRIG    = 3'd1;
  localparam logic [2:0] ST_BURST   = 3'd2;
  localparam logic [2:0] ST_ECHO    = 3'd3;
  localparam logic [2:0] ST_HOLDOFF = 3'd4;

  logic          sync1_q;
  logic          trig_s_q;
  logic          trig_prev_q;
  logic          trig_rise_s;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] width_q, width_d;
  logic          echo_q, echo_d;
  logic          busy_q, busy_d;
  logic          short_q, short_d;

  logic [XW-1:0] product_s;
  logic [CW-1:0] width_calc_s;

  // Two-flop synchroniser for the asynchronous trigger plus edge-history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b0;
      trig_s_q    <= 1'b0;
      trig_prev_q <= 1'b0;
    end else begin
      sync1_q     <= trig;
      trig_s_q    <= sync1_q;
      trig_prev_q <= trig_s_q;
    end
  end

  assign trig_rise_s = trig_s_q & ~trig_prev_q;

  // Echo width from the live distance inputs; only captured on accepted fall.
  always_comb begin
    product_s = XW'(dist_cm) * CPC_X;
    if (no_object || (dist_cm == 9'd0) || (product_s > MAX_X)) begin
      width_calc_s = MAX_C;
    end else begin
      width_calc_s = CW'(product_s);
    end
  end

  // Next-state logic for the trigger/burst/echo/holdoff sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    echo_d  = echo_q;
    busy_d  = busy_q;
    short_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        echo_d = 1'b0;
        busy_d = 1'b0;
        if (trig_rise_s) begin
          state_d = ST_TRIG;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = CNT_ZERO;
        end
      end

      ST_TRIG: begin
        if (trig_s_q) begin
          // Saturate so an arbitrarily long trigger never wraps to "short".
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            cnt_d = cnt_q;
          end
        end else if (cnt_q >= MIN_C) begin
          width_d = width_calc_s;
          busy_d  = 1'b1;
          state_d = ST_BURST;
          cnt_d   = CNT_ONE;
        end else begin
          short_d = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      end

      ST_BURST: begin
        // cnt_q equals the number of edges since the accepted fall.
        if (cnt_q == BURST_C) begin
          state_d = ST_ECHO;
          echo_d  = 1'b1;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_ECHO: begin
        if (cnt_q == width_q) begin
          state_d = ST_HOLDOFF;
          echo_d  = 1'b0;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      ST_HOLDOFF: begin
        // Trigger activity is ignored here; the edge history keeps tracking,
        // so a trigger still high at the end needs a fresh rise in IDLE.
        if (cnt_q == HOLD_C) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        echo_d  = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      width_q <= CNT_ZERO;
      echo_q  <= 1'b0;
      busy_q  <= 1'b0;
      short_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      width_q <= width_d;
      echo_q  <= echo_d;
      busy_q  <= busy_d;
      short_q <= short_d;
    end
  end

  assign echo       = echo_q;
  assign busy       = busy_q;
  assign short_trig = short_q;

endmodule

// File: tb/tb_ultrasonic_echo_responder.sv
// ---------------------------------------------------------------------------
// Testbench for ultrasonic_echo_responder with small timing parameters.
// A timestamp-based model predicts echo/busy/short_trig every cycle; directed
// scenarios add literal checks on pulse widths, latency and pulse counts, and
// a randomized phase follows.
// ---------------------------------------------------------------------------
module tb_ultrasonic_echo_responder;

  localparam int CPC   = 4;
  localparam int MINT  = 10;
  localparam int BURST = 20;
  localparam int MAXE  = 400;
  localparam int HOLD  = 50;

  bit         clk = 1'b0;
  logic       rst;
  logic       trig;
  logic [8:0] dist_cm;
  logic       no_object;
  logic       echo;
  logic       busy;
  logic       short_trig;

  ultrasonic_echo_responder #(
    .CYCLES_PER_CM  (CPC),
    .MIN_TRIG_CYCLES(MINT),
    .BURST_CYCLES   (BURST),
    .MAX_ECHO_CYCLES(MAXE),
    .HOLDOFF_CYCLES (HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .trig      (trig),
    .dist_cm   (dist_cm),
    .no_object (no_object),
    .echo      (echo),
    .busy      (busy),
    .short_trig(short_trig)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // ---------------- behavioural model (event timestamps) ----------------
  int cyc = 0;
  bit m_s1, m_s2, m_prev;
  bit m_in_trig;
  int m_hc;
  int m_echo_start = -1, m_echo_end = -1;
  int m_busy_start = -1, m_busy_end = -1;
  int m_short_at   = -1;
  bit exp_echo, exp_busy, exp_short;

  initial begin : model
    int w;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_s1 = 1'b0; m_s2 = 1'b0; m_prev = 1'b0;
        m_in_trig = 1'b0; m_hc = 0;
        m_echo_start = -1; m_echo_end = -1;
        m_busy_start = -1; m_busy_end = -1;
        m_short_at = -1;
      end else begin
        if (cyc > m_busy_end) begin
          if (m_in_trig) begin
            if (m_s2) begin
              m_hc++;
            end else begin
              m_in_trig = 1'b0;
              if (m_hc >= MINT) begin
                if (no_object || dist_cm == 9'd0 || int'(dist_cm) * CPC > MAXE) w = MAXE;
                else w = int'(dist_cm) * CPC;
                m_busy_start = cyc;
                m_echo_start = cyc + BURST;
                m_echo_end   = m_echo_start + w;
                m_busy_end   = m_echo_end + HOLD;
              end else begin
                m_short_at = cyc;
              end
            end
          end else if (m_s2 && !m_prev) begin
            m_in_trig = 1'b1;
            m_hc = 1;
          end
        end
        m_prev = m_s2;
        m_s2   = m_s1;
        m_s1   = trig;
      end
      exp_echo  = (cyc >= m_echo_start) && (cyc < m_echo_end);
      exp_busy  = (cyc >= m_busy_start) && (cyc < m_busy_end);
      exp_short = (cyc == m_short_at);
    end
  end

  // ---------------- per-cycle compare and pulse monitor ----------------
  bit mon_echo_prev = 1'b0, mon_busy_prev = 1'b0;
  int echo_run = 0, busy_run = 0;
  int last_w = 0, last_busy_len = 0;
  int echo_count = 0, short_count = 0, echo_rise_cyc = 0;

  initial begin : compare
    forever begin
      @(negedge clk);
      if (chk_en) begin
        vectors++;
        if (echo !== exp_echo || busy !== exp_busy || short_trig !== exp_short) begin
          miscompares++;
          $display("FAIL cycle_check cyc=%0d echo/busy/short got %b%b%b want %b%b%b",
                   cyc, echo, busy, short_trig, exp_echo, exp_busy, exp_short);
        end
        if (echo) begin
          if (!mon_echo_prev) begin
            echo_count++;
            echo_rise_cyc = cyc;
            echo_run = 0;
          end
          echo_run++;
        end else if (mon_echo_prev) begin
          last_w = echo_run;
        end
        if (busy) begin
          if (!mon_busy_prev) busy_run = 0;
          busy_run++;
        end else if (mon_busy_prev) begin
          last_busy_len = busy_run;
        end
        if (short_trig) short_count++;
        mon_echo_prev = echo;
        mon_busy_prev = busy;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int len);
    trig = 1'b1;
    tick(len);
    trig = 1'b0;
  endtask

  task automatic check_lit(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, act, expv);
    end
  endtask

  task automatic wait_idle();
    int k;
    bit done;
    done = 1'b0;
    tick(4);
    for (k = 0; k < 2000 && !done; k++) begin
      if (!exp_busy && !m_in_trig && cyc > m_busy_end && !trig) done = 1'b1;
      else @(negedge clk);
    end
    tick(2);
    check_lit("wait_idle_timeout", int'(done), 1);
  endtask

  task automatic wait_echo(input bit lvl);
    int k;
    k = 0;
    while (exp_echo != lvl && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check_lit("wait_echo_timeout", int'(exp_echo == lvl), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int start, sc, ec;
    rst = 1'b1; trig = 1'b0; dist_cm = 9'd0; no_object = 1'b0;
    tick(1);
    chk_en = 1'b1;
    tick(2);
    check_lit("reset_echo", int'(echo), 0);
    check_lit("reset_busy", int'(busy), 0);
    check_lit("reset_short", int'(short_trig), 0);
    rst = 1'b0;
    tick(3);

    // 1: distance 25 -> 100-cycle echo, rise 34 edges after trig first sampled
    dist_cm = 9'd25;
    ec = echo_count;
    start = cyc + 1;
    pulse(12);
    wait_idle();
    check_lit("s1_width", last_w, 100);
    check_lit("s1_latency", echo_rise_cyc - start, 34);
    check_lit("s1_busy_len", last_busy_len, 170);
    check_lit("s1_echo_count", echo_count - ec, 1);

    // 2: short trigger, plus the 9/10 boundary
    sc = short_count; ec = echo_count;
    pulse(5);
    wait_idle();
    check_lit("s2_short_count", short_count - sc, 1);
    check_lit("s2_no_echo", echo_count - ec, 0);
    pulse(9);
    wait_idle();
    check_lit("s2_len9_short", short_count - sc, 2);
    pulse(10);
    wait_idle();
    check_lit("s2_len10_width", last_w, 100);
    check_lit("s2_len10_short", short_count - sc, 2);

    // 3: clamp cases and product boundary
    no_object = 1'b1; pulse(12); wait_idle();
    check_lit("s3_no_object", last_w, 400);
    no_object = 1'b0; dist_cm = 9'd0; pulse(12); wait_idle();
    check_lit("s3_dist0", last_w, 400);
    dist_cm = 9'd200; pulse(12); wait_idle();
    check_lit("s3_dist200", last_w, 400);
    dist_cm = 9'd100; pulse(12); wait_idle();
    check_lit("s3_dist100", last_w, 400);
    dist_cm = 9'd99; pulse(12); wait_idle();
    check_lit("s3_dist99", last_w, 396);

    // 4: triggers during ECHO and HOLDOFF are ignored
    dist_cm = 9'd25;
    ec = echo_count;
    pulse(12);
    wait_echo(1'b1);
    tick(10);
    pulse(12);
    wait_echo(1'b0);
    tick(5);
    pulse(12);
    wait_idle();
    check_lit("s4_single_echo", echo_count - ec, 1);
    pulse(12);
    wait_idle();
    check_lit("s4_second_echo", echo_count - ec, 2);
    check_lit("s4_second_width", last_w, 100);

    // 5: distance change during BURST does not affect the pulse
    dist_cm = 9'd25;
    pulse(12);
    tick(6);
    dist_cm = 9'd50;
    wait_idle();
    check_lit("s5_width", last_w, 100);
    dist_cm = 9'd25;

    // 6: reset during ECHO drops echo and busy on that edge
    pulse(12);
    wait_echo(1'b1);
    tick(29);
    rst = 1'b1;
    tick(1);
    check_lit("s6_echo_dropped", int'(echo), 0);
    check_lit("s6_busy_dropped", int'(busy), 0);
    rst = 1'b0;
    check_lit("s6_partial_width", last_w, 30);
    tick(3);
    pulse(12);
    wait_idle();
    check_lit("s6_full_after_reset", last_w, 100);

    // randomized phase
    for (int it = 0; it < 40; it++) begin
      dist_cm   = 9'($urandom_range(0, 130));
      no_object = ($urandom_range(0, 7) == 0);
      pulse($urandom_range(6, 14));
      if ($urandom_range(0, 3) == 0) begin
        tick($urandom_range(0, 60));
        dist_cm = 9'($urandom_range(0, 511));
      end
      if ($urandom_range(0, 3) == 0) begin
        tick($urandom_range(0, 200));
        pulse($urandom_range(1, 12));
      end
      if ($urandom_range(0, 9) == 0) begin
        tick($urandom_range(0, 100));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      wait_idle();
      tick($urandom_range(0, 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
